// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video pipeline types and constants
package video_pkg;

  localparam int P_WIDTH_DEF  = 640;
  localparam int P_HEIGHT_DEF = 480;

  // Four 8-bit pixels are packed per 32-bit word
  function automatic int frame_words(input int width, input int height);
    return width * height / 4;
  endfunction

  localparam int FRAME_WORDS = frame_words(P_WIDTH_DEF, P_HEIGHT_DEF);

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } store_state_t;

endpackage

// File: rtl/video_in_store_if.sv
// rtl/video_in_store_if.sv - Wishbone burst-write bus between frame store and memory
interface video_in_store_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_o, sel, cti, bte,
    input  ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_o, sel, cti, bte,
    output ack
  );

endinterface

// File: rtl/video_in_addr_gen.sv
// rtl/video_in_addr_gen.sv - frame position, burst beat and ping-pong buffer tracking
module video_in_addr_gen
  import video_pkg::*;
#(
  parameter int p_BURST       = 8,
  parameter int p_FRAME_WORDS = FRAME_WORDS
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        advance,
  input  logic        wrap,
  input  logic [31:0] base_addr_0,
  input  logic [31:0] base_addr_1,
  output logic [31:0] wb_adr,
  output logic        cur_buffer,
  output logic        last_beat,
  output logic        frame_end,
  output logic        frame_last_word
);

  localparam int CNT_W  = $clog2(p_FRAME_WORDS + 1);
  localparam int BEAT_W = (p_BURST > 1) ? $clog2(p_BURST) : 1;

  logic [CNT_W-1:0]  word_cnt;
  logic [BEAT_W-1:0] beat;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      word_cnt   <= '0;
      beat       <= '0;
      cur_buffer <= 1'b0;
    end else if (advance) begin
      word_cnt <= word_cnt + CNT_W'(1);
      beat     <= last_beat ? '0 : beat + BEAT_W'(1);
    end else if (wrap) begin
      word_cnt   <= '0;
      cur_buffer <= ~cur_buffer;
    end
  end

  assign last_beat       = (beat == BEAT_W'(p_BURST - 1));
  assign frame_end       = (word_cnt == CNT_W'(p_FRAME_WORDS));
  assign frame_last_word = (word_cnt == CNT_W'(p_FRAME_WORDS - 1));

  // Base is re-sampled every beat; software only rewrites the idle buffer's base
  assign wb_adr = (cur_buffer ? base_addr_1 : base_addr_0) + (32'(word_cnt) << 2);

endmodule

// File: rtl/video_in_store.sv
// rtl/video_in_store.sv - drains the capture FIFO into ping-pong frame buffers via Wishbone bursts
module video_in_store
  import video_pkg::*;
#(
  parameter int p_WIDTH   = P_WIDTH_DEF,
  parameter int p_HEIGHT  = P_HEIGHT_DEF,
  parameter int p_BURST   = 8,
  parameter int p_LEVEL_W = 8
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 enable,
  input  logic [31:0]          base_addr_0,
  input  logic [31:0]          base_addr_1,
  input  logic [31:0]          fifo_data,
  input  logic [p_LEVEL_W-1:0] fifo_level,
  output logic                 fifo_r_e,
  video_in_store_if.master     wb,
  output logic                 cur_buffer,
  output logic                 frame_done
);

  localparam int FRAME_W = frame_words(p_WIDTH, p_HEIGHT);

  store_state_t state;
  logic         cyc_q;
  logic         beat_ack;
  logic         last_beat;
  logic         frame_end;
  logic         frame_last_word;

  // An ack landing on the reset edge is discarded so the abandoned word stays in the FIFO
  assign beat_ack = nRST && (state == BURST) && wb.ack;
  assign fifo_r_e = beat_ack;

  video_in_addr_gen #(
    .p_BURST       (p_BURST),
    .p_FRAME_WORDS (FRAME_W)
  ) u_addr_gen (
    .clk             (clk),
    .nRST            (nRST),
    .advance         (beat_ack),
    .wrap            ((state == DONE) && frame_end),
    .base_addr_0     (base_addr_0),
    .base_addr_1     (base_addr_1),
    .wb_adr          (wb.adr),
    .cur_buffer      (cur_buffer),
    .last_beat       (last_beat),
    .frame_end       (frame_end),
    .frame_last_word (frame_last_word)
  );

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state      <= IDLE;
      cyc_q      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (enable && (fifo_level >= p_LEVEL_W'(p_BURST))) begin
            state <= BURST;
            cyc_q <= 1'b1;
          end
        end
        BURST: begin
          if (beat_ack && last_beat) begin
            state      <= DONE;
            cyc_q      <= 1'b0;
            frame_done <= frame_last_word;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          cyc_q      <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

  assign wb.cyc   = cyc_q;
  assign wb.stb   = cyc_q;
  assign wb.we    = cyc_q;
  assign wb.dat_o = fifo_data;
  assign wb.sel   = cyc_q ? 4'b1111 : 4'b0000;
  assign wb.cti   = cyc_q ? (last_beat ? WB_CTI_EOB : WB_CTI_INCR) : WB_CTI_CLASSIC;
  assign wb.bte   = WB_BTE_LINEAR;

endmodule
